// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator SCAN controller.
// Optional emergency-stop support in the top level is enabled by ELEV_ESTOP_EN.
package elevator_pkg;

    localparam int unsigned DEF_NUM_FLOORS  = 10;
    localparam int unsigned DEF_FLOOR_WIDTH = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        CHECK     = 3'd3,
        DOOR_OPEN = 3'd4
    } state_t;

endpackage

// File: rtl/direction_checker.sv
// Reports whether any pending request lies above or below the current floor.
module direction_checker #(
    parameter int unsigned NUM_FLOORS  = 10,
    parameter int unsigned FLOOR_WIDTH = 4
) (
    input  logic [FLOOR_WIDTH-1:0] current_floor,
    input  logic [NUM_FLOORS-1:0]  pending,
    output logic                   above,
    output logic                   below
);

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i]) begin
                if (i > 32'(current_floor)) above = 1'b1;
                if (i < 32'(current_floor)) below = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_scan_controller.sv
// Single-car SCAN sequencer: latches calls, times travel and door dwell.
// Define ELEV_ESTOP_EN to add the estop input that freezes motion and door timing.
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int unsigned FLOOR_WIDTH = DEF_FLOOR_WIDTH,
    parameter int unsigned MOVE_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef ELEV_ESTOP_EN
    input  logic                   estop,
`endif
    input  logic [NUM_FLOORS-1:0]  floor_req,
    output logic [FLOOR_WIDTH-1:0] current_floor,
    output logic [NUM_FLOORS-1:0]  pending,
    output logic                   motor_up,
    output logic                   motor_down,
    output logic                   door_open,
    output logic                   arrive,
    output logic                   dir_up
);

    localparam int unsigned MOVE_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int unsigned DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR = FLOOR_WIDTH'(NUM_FLOORS - 1);
    localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    state_t                   state, state_next;
    state_t                   scan_state_c;
    logic                     scan_dir_c;
    logic                     dir_next;
    logic [MOVE_W-1:0]        move_cnt, move_cnt_next;
    logic [DOOR_W-1:0]        door_cnt, door_cnt_next;
    logic [FLOOR_WIDTH-1:0]   floor_next;
    logic                     arrive_next;
    logic [NUM_FLOORS-1:0]    clear_mask_c;
    logic                     above_c, below_c, here_c, hold_c;

    direction_checker #(
        .NUM_FLOORS  (NUM_FLOORS),
        .FLOOR_WIDTH (FLOOR_WIDTH)
    ) u_dir (
        .current_floor (current_floor),
        .pending       (pending),
        .above         (above_c),
        .below         (below_c)
    );

`ifdef ELEV_ESTOP_EN
    assign hold_c = estop;
`else
    assign hold_c = 1'b0;
`endif

    assign here_c = pending[current_floor];

    // SCAN decision: keep heading while demand remains ahead, otherwise reverse or rest.
    always_comb begin
        scan_state_c = IDLE;
        scan_dir_c   = dir_up;
        if (dir_up ? above_c : below_c) begin
            scan_state_c = dir_up ? MOVE_UP : MOVE_DOWN;
        end else if (dir_up ? below_c : above_c) begin
            scan_state_c = dir_up ? MOVE_DOWN : MOVE_UP;
            scan_dir_c   = ~dir_up;
        end
    end

    always_comb begin
        state_next    = state;
        dir_next      = dir_up;
        move_cnt_next = move_cnt;
        door_cnt_next = door_cnt;
        floor_next    = current_floor;
        arrive_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (here_c) begin
                    state_next = DOOR_OPEN;
                end else if (!hold_c) begin
                    if (above_c && (dir_up || !below_c)) begin
                        state_next = MOVE_UP;
                        dir_next   = DIR_UP;
                    end else if (below_c) begin
                        state_next = MOVE_DOWN;
                        dir_next   = DIR_DOWN;
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (!hold_c) begin
                    if (move_cnt == MOVE_LAST) begin
                        move_cnt_next = '0;
                        arrive_next   = 1'b1;
                        floor_next    = (state == MOVE_UP) ? current_floor + FLOOR_WIDTH'(1)
                                                           : current_floor - FLOOR_WIDTH'(1);
                        state_next    = CHECK;
                    end else begin
                        move_cnt_next = move_cnt + MOVE_W'(1);
                    end
                end
            end
            CHECK: begin
                if (here_c) begin
                    state_next = DOOR_OPEN;
                end else if (scan_state_c == IDLE) begin
                    state_next = IDLE;
                end else if (!hold_c) begin
                    state_next = scan_state_c;
                    dir_next   = scan_dir_c;
                end
            end
            DOOR_OPEN: begin
                if (!hold_c) begin
                    if (door_cnt == DOOR_LAST) begin
                        door_cnt_next = '0;
                        state_next    = scan_state_c;
                        dir_next      = scan_dir_c;
                    end else begin
                        door_cnt_next = door_cnt + DOOR_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The served floor's call is dropped from door entry until the door closes.
    always_comb begin
        clear_mask_c = '0;
        if (state_next == DOOR_OPEN || state == DOOR_OPEN) begin
            clear_mask_c = NUM_FLOORS'(1) << current_floor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            dir_up        <= DIR_UP;
            move_cnt      <= '0;
            door_cnt      <= '0;
            current_floor <= '0;
            arrive        <= 1'b0;
            pending       <= '0;
            motor_up      <= 1'b0;
            motor_down    <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state         <= state_next;
            dir_up        <= dir_next;
            move_cnt      <= move_cnt_next;
            door_cnt      <= door_cnt_next;
            current_floor <= floor_next;
            arrive        <= arrive_next;
            pending       <= (pending | floor_req) & ~clear_mask_c;
            motor_up      <= (state_next == MOVE_UP) && !hold_c;
            motor_down    <= (state_next == MOVE_DOWN) && !hold_c;
            door_open     <= (state_next == DOOR_OPEN);
        end
    end

    // Travel must never be commanded past either end of the shaft.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(motor_up && current_floor == TOP_FLOOR));
            assert (!(motor_down && current_floor == '0));
        end
    end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Scoreboard bench for elevator_scan_controller: expected arrive/door events are queued
// by the stimulus and consumed by an independent monitor.
module tb_elevator_scan_controller;

    localparam int EV_ARR  = 0;
    localparam int EV_DOOR = 1;

    typedef struct {
        int kind;
        int floor;
        int dir;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] floor_req = '0;
    logic [3:0] current_floor;
    logic [9:0] pending;
    logic       motor_up, motor_down, door_open, arrive, dir_up;
`ifdef ELEV_ESTOP_EN
    logic       estop = 1'b0;
`endif

    elevator_scan_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef ELEV_ESTOP_EN
        .estop         (estop),
`endif
        .floor_req     (floor_req),
        .current_floor (current_floor),
        .pending       (pending),
        .motor_up      (motor_up),
        .motor_down    (motor_down),
        .door_open     (door_open),
        .arrive        (arrive),
        .dir_up        (dir_up)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_total = 0;
    int   n_pass  = 0;
    ev_t  exp_q[$];
    int   mot_cycles = 0;
    int   door_cycles = 0;
    int   excl_bad = 0;
    logic door_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int kind, input int floor, input int dir, input int at);
        ev_t e;
        e.kind = kind; e.floor = floor; e.dir = dir; e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind);
        ev_t e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: kind %0d floor %0d dir %0d cycle %0d, none expected",
                     kind, current_floor, dir_up, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.floor == int'(current_floor) && e.dir == int'(dir_up) && e.cyc == cyc)
                n_pass++;
            else
                $display("FAIL event: got kind %0d floor %0d dir %0d cycle %0d, expected kind %0d floor %0d dir %0d cycle %0d",
                         kind, current_floor, dir_up, cyc, e.kind, e.floor, e.dir, e.cyc);
        end
    endtask

    // Monitor: consumes expected events whenever the car arrives or the door opens.
    always @(negedge clk) begin
        if (rst_n) begin
            if (motor_up || motor_down) mot_cycles++;
            if (door_open) door_cycles++;
            if (int'(motor_up) + int'(motor_down) + int'(door_open) > 1) excl_bad++;
            if (arrive) take(EV_ARR);
            if (door_open && !door_prev) begin
                take(EV_DOOR);
                chk("door_clear", int'(pending[current_floor]), 0);
            end
        end
        door_prev = door_open;
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input logic [9:0] m, output int e0);
        @(negedge clk);
        floor_req = m;
        e0 = cyc + 1;
        @(negedge clk);
        floor_req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e0, e1, m0, d0;

        repeat (3) @(negedge clk);
        chk("rst_floor", int'(current_floor), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_dir", int'(dir_up), 1);
        chk("rst_motors", int'({motor_up, motor_down}), 0);
        chk("rst_door", int'(door_open), 0);
        chk("rst_arrive", int'(arrive), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Floor 0 -> 3 from idle
        m0 = mot_cycles; d0 = door_cycles;
        pulse(10'(1 << 3), e0);
        for (int f = 1; f <= 3; f++) push(EV_ARR, f, 1, e0 + 9 * f);
        push(EV_DOOR, 3, 1, e0 + 28);
        wait_cyc(e0 + 50);
        chk("t1_motor_cycles", mot_cycles - m0, 24);
        chk("t1_door_cycles", door_cycles - d0, 16);
        chk("t1_floor", int'(current_floor), 3);
        chk("t1_pending", int'(pending), 0);

        // Position at 5, then travel to 8 with a call for 2 arriving mid-trip
        pulse(10'(1 << 5), e0);
        push(EV_ARR, 4, 1, e0 + 9);
        push(EV_ARR, 5, 1, e0 + 18);
        push(EV_DOOR, 5, 1, e0 + 19);
        wait_cyc(e0 + 40);
        chk("t2_floor5", int'(current_floor), 5);
        pulse(10'(1 << 8), e0);
        for (int f = 6; f <= 8; f++) push(EV_ARR, f, 1, e0 + 9 * (f - 5));
        push(EV_DOOR, 8, 1, e0 + 28);
        for (int f = 7; f >= 2; f--) push(EV_ARR, f, 0, e0 + 52 + 9 * (7 - f));
        push(EV_DOOR, 2, 0, e0 + 98);
        wait_cyc(e0 + 11);
        pulse(10'(1 << 2), e1);
        wait_cyc(e1 + 2);
        chk("t2_pending_mid", int'(pending), 10'h104);
        wait_cyc(e0 + 120);
        chk("t2_floor2", int'(current_floor), 2);
        chk("t2_dir", int'(dir_up), 0);

        // Serve own floor from idle; repeat call during door is absorbed
        pulse(10'(1 << 4), e0);
        push(EV_ARR, 3, 1, e0 + 9);
        push(EV_ARR, 4, 1, e0 + 18);
        push(EV_DOOR, 4, 1, e0 + 19);
        wait_cyc(e0 + 40);
        m0 = mot_cycles; d0 = door_cycles;
        pulse(10'(1 << 4), e0);
        push(EV_DOOR, 4, 1, e0 + 1);
        wait_cyc(e0 + 5);
        pulse(10'(1 << 4), e1);
        wait_cyc(e1 + 2);
        chk("t3_absorbed", int'(pending), 0);
        wait_cyc(e0 + 30);
        chk("t3_door_cycles", door_cycles - d0, 16);
        chk("t3_no_motor", mot_cycles - m0, 0);

        // Top floor with calls only below
        pulse(10'(1 << 9), e0);
        for (int f = 5; f <= 9; f++) push(EV_ARR, f, 1, e0 + 9 * (f - 4));
        push(EV_DOOR, 9, 1, e0 + 46);
        wait_cyc(e0 + 70);
        chk("t4_floor9", int'(current_floor), 9);
        m0 = 0;
        pulse(10'((1 << 6) | (1 << 1)), e0);
        for (int f = 8; f >= 6; f--) push(EV_ARR, f, 0, e0 + 9 * (9 - f));
        push(EV_DOOR, 6, 0, e0 + 28);
        for (int f = 5; f >= 1; f--) push(EV_ARR, f, 0, e0 + 52 + 9 * (5 - f));
        push(EV_DOOR, 1, 0, e0 + 89);
        while (cyc < e0 + 110) begin
            @(negedge clk);
            if (motor_up) m0++;
        end
        chk("t4_motor_up_never", m0, 0);
        chk("t4_floor1", int'(current_floor), 1);

        // Asynchronous reset while moving up past 6
        pulse(10'(1 << 8), e0);
        for (int f = 2; f <= 6; f++) push(EV_ARR, f, 1, e0 + 9 * (f - 1));
        wait_cyc(e0 + 50);
        chk("t5_floor6", int'(current_floor), 6);
        chk("t5_moving", int'(motor_up), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_floor", int'(current_floor), 0);
        chk("t5_pending", int'(pending), 0);
        chk("t5_motors", int'({motor_up, motor_down}), 0);
        chk("t5_door", int'(door_open), 0);
        chk("t5_dir", int'(dir_up), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef ELEV_ESTOP_EN
        // Emergency stop for 20 cycles at move count 3
        pulse(10'(1 << 2), e0);
        push(EV_ARR, 1, 1, e0 + 29);
        push(EV_ARR, 2, 1, e0 + 38);
        push(EV_DOOR, 2, 1, e0 + 39);
        wait_cyc(e0 + 4);
        estop = 1'b1;
        wait_cyc(e0 + 10);
        chk("t6_motor_frozen", int'(motor_up), 0);
        chk("t6_floor_held", int'(current_floor), 0);
        wait_cyc(e0 + 24);
        estop = 1'b0;
        wait_cyc(e0 + 26);
        chk("t6_motor_resumed", int'(motor_up), 1);
        wait_cyc(e0 + 60);
        chk("t6_floor2", int'(current_floor), 2);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("exclusive", excl_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/elevator_scan_controller.md
Name: elevator_scan_controller

Overview:
- Sequencing FSM for the single-car elevator.
- Latches floor call requests into a pending vector and drives the car up and down using SCAN ordering: it keeps its direction while requests remain ahead.
- Times per-floor travel and door dwell.
- Sits between the call-button logic and the motor/door actuators.
- Uses the existing direction_checker to decide above/below demand.

Parameters:
- NUM_FLOORS, 10: number of floors (0 to NUM_FLOORS-1).
- FLOOR_WIDTH, 4: width of floor index; must satisfy 2**FLOOR_WIDTH >= NUM_FLOORS.
- MOVE_CYCLES, 8: clock cycles of travel between adjacent floors; must be >= 1.
- DOOR_CYCLES, 16: clock cycles the door stays open; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- floor_req  input  NUM_FLOORS  call request bits, sampled every cycle; may be single-cycle pulses
- current_floor  output  FLOOR_WIDTH  registered car position
- pending  output  NUM_FLOORS  latched unserved requests
- motor_up  output  1  car travelling up
- motor_down  output  1  car travelling down
- door_open  output  1  door held open
- arrive  output  1  one-cycle pulse when current_floor changes
- dir_up  output  1  last/held travel direction; 1 = up

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; current_floor=0; pending=0; dir_up=1.
  - motor_up, motor_down, door_open and arrive all 0; timers 0.
- Request latching: pending <= (pending | floor_req) & ~clear_mask.
  - clear_mask has bit current_floor set only on the cycle the FSM enters DOOR_OPEN, or while in DOOR_OPEN.
  - A request for the current floor during DOOR_OPEN is absorbed and never set; the door timer is not restarted.
  - Clear wins over a simultaneous set of the same bit.
- Direction inputs: direction_checker is instantiated on registered current_floor and pending, giving above and below.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, CHECK, DOOR_OPEN.
- IDLE:
  - pending[current_floor] -> DOOR_OPEN.
  - Else above and (dir_up or !below) -> MOVE_UP, dir_up=1.
  - Else below -> MOVE_DOWN, dir_up=0.
  - Else stay.
- MOVE_UP / MOVE_DOWN:
  - motor_up or motor_down asserted; move timer counts 0..MOVE_CYCLES-1.
  - On the terminal count: current_floor +1 or -1, arrive=1 for that cycle, timer cleared, -> CHECK.
- CHECK (1 cycle, motors off):
  - pending[current_floor] -> DOOR_OPEN.
  - Else continue in dir_up direction if demand remains on that side.
  - Else reverse if the opposite side has demand (dir_up flips).
  - Else -> IDLE.
- DOOR_OPEN:
  - door_open=1 for exactly DOOR_CYCLES cycles.
  - Then apply the same rule as CHECK, except pending[current_floor] is ignored.
- Latency: a request N floors away, sampled at edge E0 while IDLE, asserts door_open after N*(MOVE_CYCLES+1)+1 cycles. N=0 gives 1 cycle.
- Boundaries:
  - Never moves above NUM_FLOORS-1 or below 0; above/below are inherently 0 there.
  - A simulation assertion fires if motor_up is asserted at the top floor, or motor_down at floor 0.
  - Request bits for indices >= NUM_FLOORS do not exist.
- Exclusivity: motor_up, motor_down and door_open are mutually exclusive every cycle.
- Reset mid-move: the car snaps to floor 0 logically; this is accepted behaviour for the model.

Optional Feature:
- Macro: ELEV_ESTOP_EN.
- With the macro defined:
  - Adds input estop (1 bit).
  - While estop=1 in MOVE_UP/MOVE_DOWN: motors are 0, the move timer freezes, and the state is held.
  - While estop=1 in DOOR_OPEN: the door timer freezes and the door stays open.
  - In IDLE/CHECK, transitions to MOVE states are blocked.
  - Requests keep latching throughout.
  - On release, the sequence resumes from the frozen count.
- Without the macro: the port is absent and there is no freeze logic.

Decomposition:
- Package elevator_pkg holds:
  - state encoding localparams (IDLE, MOVE_UP, MOVE_DOWN, CHECK, DOOR_OPEN);
  - direction encoding (DIR_UP=1, DIR_DOWN=0);
  - default NUM_FLOORS and FLOOR_WIDTH.
- Sub-module: reuse the existing direction_checker unchanged.
- Timers stay inline; no new sub-module.

Test Plan:
1. Reset at floor 0, floor_req bit 3 pulsed one cycle -> motor_up for 3x8 cycles with 3 arrive pulses; door_open rises 28 cycles after sampling, held 16 cycles; pending[3] clears on door entry; then IDLE.
2. Car at floor 5 moving up to 8, floor_req bit 2 pulsed mid-travel -> car serves 8 first, then reverses (dir_up=0) and opens at 2.
3. IDLE at floor 4, floor_req bit 4 -> door_open next cycle, no motor activity; repeat bit 4 during DOOR_OPEN -> absorbed, pending stays 0.
4. Car at 9 with requests only below -> motor_up never asserted; car descends to highest pending below.
5. Assert rst_n=0 mid-move at floor 6 -> all outputs 0 immediately (async); current_floor=0, pending=0.
6. (ELEV_ESTOP_EN) Assert estop for 20 cycles at move count 3 -> motors 0 and count held at 3; arrival is delayed by exactly 20 cycles.
